// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, mux selects,
// ALUOp values, FSM states and the per-state control bundle.
package multicycle_main_fsm_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational Moore decode: current FSM state to the control bundle.
module multicycle_ctrl_decode
  import multicycle_main_fsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
      end
      // Speculatively compute the branch target into ALUOut.
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      // PC takes the target from ALUOut while ALU forms the link address.
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core: state register, opcode
// dispatch, PC write enable and reset gating of all write strobes.
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
#(
  parameter logic TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic       Halted
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;
  logic   illegal_op;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    illegal_op = 1'b0;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            illegal_op = 1'b1;
            state_next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMREAD;
        else if (op == OP_SW) state_next = S_MEMWRITE;
        else                  state_next = S_FETCH;
      end
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state (state_reg),
    .ctrl  (ctrl)
  );

  // Write strobes are held low while reset is asserted so an abandoned
  // instruction can never commit a partial write.
  assign PCWrite   = ~reset & (ctrl.pc_update | (ctrl.branch & Zero));
  assign IRWrite   = ~reset & ctrl.ir_write;
  assign MemWrite  = ~reset & ctrl.mem_write;
  assign RegWrite  = ~reset & ctrl.reg_write;
  assign IllegalOp = ~reset & illegal_op;

  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign Halted    = ctrl.halted;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm; two instances cover both settings
// of TRAP_ON_ILLEGAL and share one stimulus stream.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic       Zero = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp, Halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_RegWrite, t_IllegalOp, t_Halted;
  logic [1:0] t_ResultSrc, t_ALUSrcA, t_ALUSrcB, t_ALUOp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .Halted(Halted)
  );

  multicycle_main_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(t_PCWrite), .AdrSrc(t_AdrSrc), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite),
    .ResultSrc(t_ResultSrc), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .RegWrite(t_RegWrite),
    .ALUOp(t_ALUOp), .IllegalOp(t_IllegalOp), .Halted(t_Halted)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ALUOp,IllegalOp,Halted}
  wire [14:0] obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, RegWrite, ALUOp, IllegalOp, Halted};
  wire [14:0] obs_t = {t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_ResultSrc, t_ALUSrcA,
                       t_ALUSrcB, t_RegWrite, t_ALUOp, t_IllegalOp, t_Halted};

  localparam logic [14:0] V_FETCH     = 15'b1_0_0_1_10_00_10_0_00_0_0;
  localparam logic [14:0] V_RST_FETCH = 15'b0_0_0_0_10_00_10_0_00_0_0;
  localparam logic [14:0] V_DECODE    = 15'b0_0_0_0_00_01_01_0_00_0_0;
  localparam logic [14:0] V_DEC_ILL   = 15'b0_0_0_0_00_01_01_0_00_1_0;
  localparam logic [14:0] V_MEMADR    = 15'b0_0_0_0_00_10_01_0_00_0_0;
  localparam logic [14:0] V_MEMREAD   = 15'b0_1_0_0_00_00_00_0_00_0_0;
  localparam logic [14:0] V_MEMWB     = 15'b0_0_0_0_01_00_00_1_00_0_0;
  localparam logic [14:0] V_MEMWRITE  = 15'b0_1_1_0_00_00_00_0_00_0_0;
  localparam logic [14:0] V_MEMW_RST  = 15'b0_1_0_0_00_00_00_0_00_0_0;
  localparam logic [14:0] V_EXECR     = 15'b0_0_0_0_00_10_00_0_10_0_0;
  localparam logic [14:0] V_EXECI     = 15'b0_0_0_0_00_10_01_0_10_0_0;
  localparam logic [14:0] V_ALUWB     = 15'b0_0_0_0_00_00_00_1_00_0_0;
  localparam logic [14:0] V_BEQ_T     = 15'b1_0_0_0_00_10_00_0_01_0_0;
  localparam logic [14:0] V_BEQ_NT    = 15'b0_0_0_0_00_10_00_0_01_0_0;
  localparam logic [14:0] V_JAL       = 15'b1_0_0_0_00_01_10_0_00_0_0;
  localparam logic [14:0] V_HALT      = 15'b0_0_0_0_00_00_00_0_00_0_1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 7'b0000011;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== V_RST_FETCH) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%b want=%b", i, obs, V_RST_FETCH);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      failures++;
      $display("FAIL reset_release got=%b want=%b", obs, V_FETCH);
    end
    $display("tb: reset sequence done");
  endtask

  task automatic test_lw();
    logic [14:0] exp [5];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
    op   = 7'b0000011;
    Zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL lw_cycle%0d got=%b want=%b", i + 1, obs, exp[i]);
      end
      step();
    end
    $display("tb: lw done");
  endtask

  task automatic test_sw();
    logic [14:0] exp [4];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE};
    op   = 7'b0100011;
    Zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL sw_cycle%0d got=%b want=%b", i + 1, obs, exp[i]);
      end
      step();
    end
    $display("tb: sw done");
  endtask

  task automatic test_alu(input logic [6:0] opcode, input logic [14:0] exec_v);
    logic [14:0] exp [4];
    exp = '{V_FETCH, V_DECODE, exec_v, V_ALUWB};
    op   = opcode;
    Zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL alu_op%b_cycle%0d got=%b want=%b", opcode, i + 1, obs, exp[i]);
      end
      step();
    end
    $display("tb: alu op=%b done", opcode);
  endtask

  task automatic test_beq(input logic zero_in);
    logic [14:0] exp [3];
    exp = '{V_FETCH, V_DECODE, zero_in ? V_BEQ_T : V_BEQ_NT};
    op   = 7'b1100011;
    Zero = zero_in;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL beq_z%0d_cycle%0d got=%b want=%b", zero_in, i + 1, obs, exp[i]);
      end
      step();
    end
    $display("tb: beq zero=%0d done", zero_in);
  endtask

  task automatic test_jal();
    logic [14:0] exp [4];
    exp = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB};
    op   = 7'b1101111;
    Zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL jal_cycle%0d got=%b want=%b", i + 1, obs, exp[i]);
      end
      step();
    end
    $display("tb: jal done");
  endtask

  task automatic test_illegal_discard();
    logic [14:0] exp [3];
    exp = '{V_FETCH, V_DEC_ILL, V_FETCH};
    op = 7'b1111111;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL illegal_cycle%0d got=%b want=%b", i + 1, obs, exp[i]);
      end
      if (i < 2) step();
    end
    $display("tb: illegal discard done");
  endtask

  task automatic test_illegal_trap();
    reset = 1'b1;
    op    = 7'b1111111;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (obs_t !== V_FETCH) begin
      failures++;
      $display("FAIL trap_fetch got=%b want=%b", obs_t, V_FETCH);
    end
    step();
    checks++;
    if (obs_t !== V_DEC_ILL) begin
      failures++;
      $display("FAIL trap_decode got=%b want=%b", obs_t, V_DEC_ILL);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_t !== V_HALT) begin
        failures++;
        $display("FAIL trap_halt[%0d] got=%b want=%b", i, obs_t, V_HALT);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs_t !== V_HALT) begin
      failures++;
      $display("FAIL trap_halt_in_reset got=%b want=%b", obs_t, V_HALT);
    end
    step();
    checks++;
    if (obs_t !== V_RST_FETCH) begin
      failures++;
      $display("FAIL trap_reset_exit got=%b want=%b", obs_t, V_RST_FETCH);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs_t !== V_FETCH || obs !== V_FETCH) begin
      failures++;
      $display("FAIL trap_refetch got=%b/%b want=%b", obs, obs_t, V_FETCH);
    end
    $display("tb: illegal trap done");
  endtask

  task automatic test_reset_mid_write();
    logic [14:0] exp [3];
    exp = '{V_FETCH, V_DECODE, V_MEMADR};
    op = 7'b0100011;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL rstmid_cycle%0d got=%b want=%b", i + 1, obs, exp[i]);
      end
      step();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_MEMW_RST) begin
      failures++;
      $display("FAIL rstmid_memwrite got=%b want=%b", obs, V_MEMW_RST);
    end
    step();
    checks++;
    if (obs !== V_RST_FETCH) begin
      failures++;
      $display("FAIL rstmid_reset_fetch got=%b want=%b", obs, V_RST_FETCH);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      failures++;
      $display("FAIL rstmid_refetch got=%b want=%b", obs, V_FETCH);
    end
    step();
    checks++;
    if (obs !== V_DECODE) begin
      failures++;
      $display("FAIL rstmid_decode got=%b want=%b", obs, V_DECODE);
    end
    $display("tb: reset during memwrite done");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu(7'b0110011, V_EXECR);
    test_alu(7'b0010011, V_EXECI);
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_illegal_discard();
    test_illegal_trap();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle RV32I core; sits directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the datapath mux selects and write enables, and supplies the 2-bit ALUOp consumed by the ALU decoder.
- Moore machine: every control output decodes from the current state only. The exceptions are PCWrite (also uses Zero) and the reset gating.

Parameters:
- TRAP_ON_ILLEGAL, 0, 1 = an unsupported opcode parks the FSM in HALT until reset; 0 = discard the instruction and return to FETCH.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  opcode field of the instruction register
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- RegWrite  out  1  register file write enable
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct fields
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- Halted  out  1  high while in HALT

Behaviour:
- Reset: the state register loads FETCH on the clock edge where reset=1.
- While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0 combinationally.
- Fields not listed for a state are 0.
- PCWrite = PCUpdate | (Branch & Zero), where PCUpdate and Branch are internal state decodes.
- State table (outputs -> next state):
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut) -> dispatch on op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> IllegalOp=1 this cycle; next state HALT if TRAP_ON_ILLEGAL=1, else FETCH
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op=lw, MEMWRITE if op=sw
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB
  - HALT: all enables 0, Halted=1 -> HALT; only reset exits
- The op input is sampled in DECODE and MEMADR only; op is stable there because IRWrite is low outside FETCH.
- Latency in cycles, FETCH through writeback: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Illegal or unreachable state encoding -> next state FETCH, all outputs 0.
- Reset mid-instruction: the instruction is abandoned, no partial write issues after the reset edge, and the next instruction fetch begins.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUOp encodings
  - ALUSrcA, ALUSrcB and ResultSrc encodings
  - state enumeration, 4 bits
- The ALU decoder reuses the ALUOp constants from this package.
- One sub-module is natural: multicycle_ctrl_decode, the pure combinational map from state to the control-output bundle.
- The state register, next-state logic, PCWrite and reset gating stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with op=0000011 -> first cycle is FETCH (IRWrite=1, PCWrite=1, ALUSrcB=10); no write enable high while reset=1.
- lw (op=0000011) -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 with ResultSrc=01 only in cycle 5.
- R-type (op=0110011) -> ALUOp=10 with ALUSrcB=00 in EXECUTER; I-type (op=0010011) -> ALUOp=10 with ALUSrcB=01; both then ALUWB with RegWrite=1.
- beq (op=1100011) with Zero=1 -> PCWrite=1 in cycle 3; repeat with Zero=0 -> PCWrite=0; ALUOp=01 in both cases.
- jal (op=1101111) -> PCWrite=1 in JAL, then ALUWB with RegWrite=1, total 4 cycles.
- op=1111111 with TRAP_ON_ILLEGAL=0 -> IllegalOp pulses one cycle, back to FETCH; with TRAP_ON_ILLEGAL=1 -> Halted=1 and all enables 0 indefinitely, cleared by reset. Reset asserted during MEMWRITE -> MemWrite=0 that cycle.
